// File: rtl/tick_speed_decoder.sv
// Tick-period speed decoder: measures the spacing of tick rising edges, classifies it
// against four nominal periods and locks after LOCK_COUNT agreeing periods.
// Optional macro TICK_SPEED_DECODER_STATS_EN adds a saturating err_count output.
//
// state   | meaning
// IDLE    | no reference event yet (after reset or timeout)
// MEASURE | reference event seen, collecting matching periods
// LOCKED  | speed/valid trustworthy
module tick_speed_decoder #(
  parameter int TOL        = 16,
  parameter int LOCK_COUNT = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        tick,
  output logic [1:0]  speed,
  output logic        valid,
  output logic        err,
  output logic [15:0] period
`ifdef TICK_SPEED_DECODER_STATS_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  MEASURE = 2'd1;
  localparam logic [1:0]  LOCKED  = 2'd2;
  localparam logic [15:0] TIMEOUT_CYC = 16'(30000 + TOL + 1);
  localparam logic [2:0]  LOCK_N      = 3'(LOCK_COUNT);

  logic [1:0]  state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic        tick_q;
  logic [1:0]  cand_q, cand_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [1:0]  speed_d;
  logic        valid_d, err_d;
  logic [15:0] period_d;
  logic [2:0]  cnt_next;
  logic        ev;
  logic        matched;
  logic [1:0]  code;

  assign ev = tick & ~tick_q;

  function automatic logic in_window(input logic [15:0] p, input int nominal);
    int pv;
    pv = int'(p);
    return (pv >= nominal - TOL) && (pv <= nominal + TOL);
  endfunction

  // Lowest code wins if windows ever overlap (only possible with a very large TOL).
  always_comb begin
    matched = 1'b0;
    code    = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (in_window(counter_q, 30000 - 5000 * i)) begin
        matched = 1'b1;
        code    = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    cand_d      = cand_q;
    match_cnt_d = match_cnt_q;
    speed_d     = speed;
    valid_d     = valid;
    err_d       = 1'b0;
    period_d    = period;
    cnt_next    = 3'd0;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d   = MEASURE;
          counter_d = 16'd1;
        end
      end
      MEASURE, LOCKED: begin
        if (ev) begin
          counter_d = 16'd1;
          period_d  = counter_q;
          if (!matched) begin
            err_d       = 1'b1;
            valid_d     = 1'b0;
            match_cnt_d = 3'd0;
            state_d     = MEASURE;
          end else if (state_q == LOCKED) begin
            if (code != cand_q) begin
              valid_d     = 1'b0;
              state_d     = MEASURE;
              cand_d      = code;
              match_cnt_d = 3'd1;
            end
          end else begin
            cnt_next    = (code == cand_q) ? match_cnt_q + 3'd1 : 3'd1;
            cand_d      = code;
            match_cnt_d = cnt_next;
            if (cnt_next >= LOCK_N) begin
              state_d = LOCKED;
              speed_d = code;
              valid_d = 1'b1;
            end
          end
        end else if (counter_q == TIMEOUT_CYC) begin
          err_d       = 1'b1;
          valid_d     = 1'b0;
          match_cnt_d = 3'd0;
          counter_d   = 16'd0;
          state_d     = IDLE;
        end else if (counter_q != 16'hFFFF) begin
          counter_d = counter_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      counter_q   <= 16'd0;
      tick_q      <= 1'b0;
      cand_q      <= 2'b00;
      match_cnt_q <= 3'd0;
      speed       <= 2'b00;
      valid       <= 1'b0;
      err         <= 1'b0;
      period      <= 16'd0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      tick_q      <= tick;
      cand_q      <= cand_d;
      match_cnt_q <= match_cnt_d;
      speed       <= speed_d;
      valid       <= valid_d;
      err         <= err_d;
      period      <= period_d;
    end
  end

`ifdef TICK_SPEED_DECODER_STATS_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      err_count <= 8'd0;
    end else if (err_d && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tick_speed_decoder.sv
// Scoreboard bench for tick_speed_decoder: a timestamp-based reference model queues
// expected outputs per event/timeout/reset, and a monitor compares them when due.
module tb_tick_speed_decoder;
  localparam int TOL        = 16;
  localparam int LOCK_COUNT = 2;
  localparam int TIMEOUT    = 30000 + TOL + 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        tick;
  logic [1:0]  speed;
  logic        valid;
  logic        err;
  logic [15:0] period;
`ifdef TICK_SPEED_DECODER_STATS_EN
  logic [7:0]  err_count;
`endif

  always #5 Clock = ~Clock;

  tick_speed_decoder #(.TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .tick   (tick),
    .speed  (speed),
    .valid  (valid),
    .err    (err),
    .period (period)
`ifdef TICK_SPEED_DECODER_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct {
    int          due;
    logic [1:0]  speed;
    logic        valid;
    logic        err;
    logic [15:0] period;
    int          errs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Reference model state: event timestamps rather than a running counter.
  bit have_ref, locked, tick_prev, follow;
  int last_ev, cand, streak, m_speed, m_period, m_errs;
  bit m_valid;

  function automatic int classify(input int p);
    for (int i = 0; i < 4; i++) begin
      int nom;
      nom = 30000 - 5000 * i;
      if (p >= nom - TOL && p <= nom + TOL) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input int n, input bit rst, input bit tk);
    bit ev, pushed, e;
    int p, code;
    exp_t x;
    pushed = 0;
    e      = 0;
    if (rst) begin
      have_ref = 0; locked = 0; tick_prev = 0; cand = 0; streak = 0;
      m_speed = 0; m_valid = 0; m_period = 0; m_errs = 0;
      pushed = 1;
    end else begin
      ev = tk && !tick_prev;
      tick_prev = tk;
      if (ev && !have_ref) begin
        have_ref = 1;
        last_ev  = n;
      end else if (ev) begin
        p = n - last_ev;
        last_ev  = n;
        m_period = p;
        code     = classify(p);
        pushed   = 1;
        if (code < 0) begin
          e = 1; m_valid = 0; locked = 0; streak = 0;
        end else if (locked) begin
          if (code != cand) begin
            locked = 0; m_valid = 0; cand = code; streak = 1;
          end
        end else begin
          streak = (code == cand) ? streak + 1 : 1;
          cand   = code;
          if (streak >= LOCK_COUNT) begin
            locked = 1; m_valid = 1; m_speed = code;
          end
        end
      end else if (have_ref && (n - last_ev) == TIMEOUT) begin
        e = 1; m_valid = 0; locked = 0; streak = 0; have_ref = 0;
        pushed = 1;
      end
    end
    if (e && m_errs < 255) m_errs++;
    if (pushed || follow) begin
      x.due    = n;
      x.speed  = 2'(m_speed);
      x.valid  = m_valid;
      x.err    = e;
      x.period = 16'(m_period);
      x.errs   = m_errs;
      q.push_back(x);
    end
    follow = e;
  endtask

  task automatic step(input bit rst, input bit tk);
    @(negedge Clock);
    Reset = rst;
    tick  = tk;
    model_step(cyc + 1, rst, tk);
  endtask

  // One event now, next event p cycles later (issued by the following call).
  task automatic pulse_period(input int p);
    int h;
    h = $urandom_range(1, 4);
    for (int i = 0; i < p; i++) step(1'b0, i < h);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge Clock);
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        x = q.pop_front();
        chk("speed",  32'(speed),  32'(x.speed));
        chk("valid",  32'(valid),  32'(x.valid));
        chk("err",    32'(err),    32'(x.err));
        chk("period", 32'(period), 32'(x.period));
`ifdef TICK_SPEED_DECODER_STATS_EN
        chk("err_count", 32'(err_count), 32'(x.errs));
`endif
      end else if (q.size() > 0 && q[0].due < cyc) begin
        total++;
        bad++;
        $display("FAIL stale_expect at cycle %0d: got no check expected due %0d", cyc, q[0].due);
        x = q.pop_front();
      end else if (err !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL spurious_err at cycle %0d: got %b expected 0", cyc, err);
      end
    end
  end

  initial begin : stim
    int nom, off;
    Reset = 1'b1;
    tick  = 1'b0;
    have_ref = 0; locked = 0; tick_prev = 0; follow = 0;
    cand = 0; streak = 0; m_speed = 0; m_valid = 0; m_period = 0; m_errs = 0; last_ev = 0;

    // Reset with tick already high: first cycle after release is an event.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    pulse_period(20000);
    pulse_period(20000);
    pulse_period(15000);   // third event locks at 2'b10
    pulse_period(15016);   // different code, valid drops
    pulse_period(14983);   // +TOL edge relocks 2'b11
    pulse_period(25016);   // one below -TOL: err
    pulse_period(25017);   // +TOL edge matches 2'b01
    for (int k = 0; k < 2; k++) begin   // first of these classifies 25017: err
      nom = 30000 - 5000 * int'($urandom_range(0, 3));
      off = int'($urandom_range(0, 48)) - 24;
      pulse_period(nom + off);
    end
    pulse_period(30000);
    pulse_period(30000);
    pulse_period(200);     // locked at 2'b00

    step(1'b1, 1'b0);      // one-cycle reset mid-lock
    pulse_period(15000);
    pulse_period(15000);
    pulse_period(TIMEOUT + 50);   // relock, then ticks stop -> timeout
    pulse_period(100);            // fresh reference event from IDLE

    repeat (5) @(posedge Clock);
    #2;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
